pc_sequencer: RTL and testbench

Next-PC controller for the 12-bit program counter latch in the fetch stage. It decides every cycle whether the PC holds, increments, or redirects to a branch/jump target, and drives the latch's `d` input. It sequences a boot window after reset, wrong-path flush after redirects, and a terminal halt state. It also exports fetch-valid/flush qualifiers and a stall-cycle counter for the pipeline.

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch-stage PC latch: boot window, run, wrong-path flush and halt.
// pc_d is combinational so a redirect target reaches the latch in the same cycle it is requested.
module pc_sequencer #(
  parameter int unsigned          PC_W         = 12,
  parameter logic [PC_W-1:0]      RESET_PC     = '0,
  parameter int unsigned          BOOT_CYCLES  = 2,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_q,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc_d,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted,
  output logic [1:0]      state,
  output logic [15:0]     stall_cycles
);

  localparam int unsigned CntMax = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] BootLast  = CntW'(BOOT_CYCLES - 1);
  localparam logic [CntW-1:0] FlushLast = CntW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StHalt  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     stall_cycles_q, stall_cycles_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            flush_q, flush_d;
  logic            halted_q, halted_d;
  logic            stall_hit;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    stall_hit = 1'b0;

    unique case (state_q)
      StBoot: begin
        pc_d = RESET_PC;
        if (cnt_q == BootLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = StFlush;
          cnt_d   = '0;
        end else if (jump) begin
          pc_d    = jump_target;
          state_d = StFlush;
          cnt_d   = '0;
        end else if (stall) begin
          stall_hit = 1'b1;
        end else if (halt) begin
          state_d = StHalt;
        end else begin
          pc_d = pc_inc;
        end
      end
      StFlush: begin
        // A redirect on the wrong path restarts the flush window; halt here is wrong-path too.
        if (branch_taken) begin
          pc_d  = branch_target;
          cnt_d = '0;
        end else if (jump) begin
          pc_d  = jump_target;
          cnt_d = '0;
        end else begin
          if (stall) begin
            stall_hit = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
          if (cnt_q == FlushLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHalt: begin
        pc_d = pc_q;
      end
      default: begin
        state_d = StBoot;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_hit && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
    fetch_valid_d = (state_d == StRun) || (state_d == StFlush);
    flush_d       = (state_d == StFlush);
    halted_d      = (state_d == StHalt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StBoot;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
      fetch_valid_q  <= 1'b0;
      flush_q        <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      fetch_valid_q  <= fetch_valid_d;
      flush_q        <= flush_d;
      halted_q       <= halted_d;
    end
  end

  assign state        = state_q;
  assign fetch_valid  = fetch_valid_q;
  assign flush        = flush_q;
  assign halted       = halted_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, increment, redirects, flush, stall/halt, wrap, reset, saturation.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] pc_q;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic        jump;
  logic [11:0] jump_target;
  logic        halt;
  logic [11:0] pc_d;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pc_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .pc_q          (pc_q),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .pc_d          (pc_d),
    .fetch_valid   (fetch_valid),
    .flush         (flush),
    .halted        (halted),
    .state         (state),
    .stall_cycles  (stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs are then changed 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jump = 0; halt = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    pc_q  = 12'h123;
    step(); step();
    settle();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc_d", 32'(pc_d), 32'h000);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_stallcnt", 32'(stall_cycles), 32'd0);

    // Boot window: two cycles of RESET_PC with inputs ignored.
    reset = 1'b0;
    pc_q  = 12'h000;
    branch_taken = 1; branch_target = 12'h0AA;
    settle();
    check("boot0_pc_d", 32'(pc_d), 32'h000);
    check("boot0_fv", 32'(fetch_valid), 32'd0);
    step();
    check("boot1_state", 32'(state), 32'd0);
    check("boot1_pc_d", 32'(pc_d), 32'h000);
    step();
    idle_inputs();
    settle();
    check("run_state", 32'(state), 32'd1);
    check("run_fv", 32'(fetch_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      pc_q = 12'(i);
      settle();
      check("run_inc", 32'(pc_d), 32'(i + 1));
      step();
    end

    // Branch at 0x005 to 0x040.
    pc_q = 12'h005; branch_taken = 1; branch_target = 12'h040;
    settle();
    check("br_pc_d", 32'(pc_d), 32'h040);
    check("br_flush_same", 32'(flush), 32'd0);
    step();
    idle_inputs(); pc_q = 12'h040; halt = 1;
    settle();
    check("fl0_flush", 32'(flush), 32'd1);
    check("fl0_state", 32'(state), 32'd2);
    check("fl0_halt_ign", 32'(pc_d), 32'h041);
    step();
    halt = 0; pc_q = 12'h041;
    settle();
    check("fl1_flush", 32'(flush), 32'd1);
    check("fl1_pc_d", 32'(pc_d), 32'h042);
    step();
    pc_q = 12'h042;
    settle();
    check("fl_done_state", 32'(state), 32'd1);
    check("fl_done_flush", 32'(flush), 32'd0);

    // Branch and jump together: branch wins; then a jump during flush restarts it.
    pc_q = 12'h050;
    branch_taken = 1; branch_target = 12'h100;
    jump = 1; jump_target = 12'h200;
    settle();
    check("br_vs_jmp", 32'(pc_d), 32'h100);
    step();
    idle_inputs(); pc_q = 12'h100; jump = 1; jump_target = 12'h300; stall = 1;
    settle();
    check("fl_jmp_pc_d", 32'(pc_d), 32'h300);
    step();
    idle_inputs(); pc_q = 12'h300;
    settle();
    check("fl_re0_flush", 32'(flush), 32'd1);
    check("fl_re0_pc_d", 32'(pc_d), 32'h301);
    check("redir_stall_nocount", 32'(stall_cycles), 32'd0);
    step();
    pc_q = 12'h301;
    settle();
    check("fl_re1_flush", 32'(flush), 32'd1);
    step();
    pc_q = 12'h010;
    settle();
    check("fl_re_done", 32'(state), 32'd1);

    // Stall + halt for 3 cycles, then halt alone.
    stall = 1; halt = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_hold", 32'(pc_d), 32'h010);
      step();
    end
    stall = 0;
    settle();
    check("stall_cnt3", 32'(stall_cycles), 32'd3);
    check("halt_pending_state", 32'(state), 32'd1);
    check("halt_pc_d", 32'(pc_d), 32'h010);
    step();
    idle_inputs(); branch_taken = 1; branch_target = 12'h777; stall = 1;
    settle();
    check("halt_state", 32'(state), 32'd3);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_fv", 32'(fetch_valid), 32'd0);
    check("halt_frozen", 32'(pc_d), 32'h010);
    step(); step();
    check("halt_stays", 32'(state), 32'd3);
    check("halt_nocount", 32'(stall_cycles), 32'd3);

    // Recover by reset; wrap at 0xFFF; then reset asynchronously in the middle of FLUSH.
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    step(); step();
    pc_q = 12'hFFF;
    settle();
    check("wrap_pc_d", 32'(pc_d), 32'h000);
    stall = 1;
    step();
    stall = 0; branch_taken = 1; branch_target = 12'h080;
    step();
    idle_inputs(); pc_q = 12'h080;
    settle();
    check("pre_rst_flush", 32'(flush), 32'd1);
    check("pre_rst_cnt", 32'(stall_cycles), 32'd1);
    #2;
    reset = 1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_flush", 32'(flush), 32'd0);
    check("arst_cnt", 32'(stall_cycles), 32'd0);
    check("arst_pc_d", 32'(pc_d), 32'h000);

    // Long stall: counter saturates at 0xFFFF.
    step();
    reset = 0;
    step(); step();
    stall = 1;
    repeat (65534) step();
    check("sat_fffe", 32'(stall_cycles), 32'hFFFE);
    repeat (70000 - 65534) step();
    check("sat_ffff", 32'(stall_cycles), 32'hFFFF);
    stall = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
